imem_loader: RTL

//   Write-side counterpart of the instruction memory: streams a program image into it.
//   - Accepts a byte stream over a valid/ready handshake.
//   - Packs every 4 bytes into a 32-bit instruction word.
//   - Issues one write per word at consecutive word-aligned byte addresses, starting at 0.
//   - Sits between the boot/serial receive path and the instruction memory write port.
//   - The processor is held off while busy is high.

---
 rtl/imem_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream into big-endian 32-bit words
// and writes them to consecutive word addresses of the instruction memory,
// starting at address 0. busy holds the processor off during a load.
module imem_loader #(
  parameter int DEPTH = 56,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic [7:0]       byte_in_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [31:0]      wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] word_idx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      shreg_q, shreg_d;

  logic [CNT_W-1:0] word_nxt;
  logic             byte_acc;

  assign word_nxt = word_idx_q + CNT_W'(1);
  assign byte_acc = (state_q == S_RECV) && byte_valid_i;

  // State and datapath registers; reset drops any partial word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Saturate so the address can never run past the memory
          target_d   = (num_words_i > DEPTH_C) ? DEPTH_C : num_words_i;
          word_idx_d = '0;
          byte_cnt_d = '0;
          state_d    = (target_d == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (byte_acc) begin
          // First byte of a word ends up in [31:24]
          shreg_d    = {shreg_q[23:0], byte_in_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // start is not looked at here, including on the final write
        word_idx_d = word_nxt;
        state_d    = (word_nxt == target_q) ? S_DONE : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; address/data are zero outside the write cycle
  always_comb begin
    byte_ready_o = 1'b0;
    wr_en_o      = 1'b0;
    wr_addr_o    = '0;
    wr_data_o    = '0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    word_idx_o   = word_idx_q;
    unique case (state_q)
      S_RECV: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_WRITE: begin
        wr_en_o   = 1'b1;
        busy_o    = 1'b1;
        wr_addr_o = 32'({word_idx_q, 2'b00});
        wr_data_o = shreg_q;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
